serial_word_rx: RTL and testbench

Serial-to-parallel frame receiver. It is the receive end of the serial link driven by the team's shifting transmitter. It accepts one bit per sen strobe, MSB-first or LSB-first, and assembles N-bit words. Each completed word goes into a holding register with a valid/ready handshake toward the consumer logic.

---
 rtl/serial_word_rx_pkg.sv | 16 +
 rtl/serial_word_rx_bit_counter.sv | 34 +++
 rtl/serial_word_rx.sv | 116 +++++++++++
 tb/tb_serial_word_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_rx_pkg.sv
// serial_word_rx_pkg: encodings shared by the serial link receiver and its
// matching transmitter.
//   state_t        : frame FSM states (ST_IDLE, ST_SHIFT)
//   DIR_MSB_FIRST  : bit order code, first bit lands in the MSB
//   DIR_LSB_FIRST  : bit order code, first bit lands in the LSB
package serial_word_rx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_rx_bit_counter.sv
// ser_bit_counter: mod-N bit counter for the serial receiver.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   clr   : synchronous clear (has priority over en)
//   en    : advance by one (bit strobe)
//   tc    : terminal count, high while count == N-1
module ser_bit_counter #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count_q;

  assign tc = (count_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tc ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx: serial-to-parallel frame receiver with a one-word holding
// register and valid/ready handshake.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   start      : frame sync, begins (or restarts) a frame
//   dir        : bit order, latched on start (0 MSB first, 1 LSB first)
//   sin        : serial data, used only when sen=1
//   sen        : bit strobe
//   dout       : holding register
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer accepts dout
//   busy       : frame in progress
//   overrun    : one-cycle pulse when a completed word is dropped
module serial_word_rx
  import serial_word_rx_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic         sin,
  input  logic         sen,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         overrun
);

  localparam int CW = $clog2(N);

  state_t       state_q, state_d;
  logic [N-1:0] sreg_q, sreg_d;
  logic         dir_q, dir_d;
  logic [N-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  logic         overrun_q, overrun_d;

  logic         cnt_clr, cnt_en, cnt_tc;
  logic [N-1:0] shifted;
  logic         word_done;

  ser_bit_counter #(.N(N), .CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  assign shifted = (dir_q == DIR_LSB_FIRST) ? {sin, sreg_q[N-1:1]}
                                            : {sreg_q[N-2:0], sin};

  // start wins over a coincident strobe, so a restart never completes a word
  assign word_done = (state_q == ST_SHIFT) && !start && sen && cnt_tc;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    dir_d     = dir_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    if (start) begin
      state_d = ST_SHIFT;
      dir_d   = dir;
      sreg_d  = '0;
      cnt_clr = 1'b1;
    end else if (state_q == ST_SHIFT && sen) begin
      sreg_d = shifted;
      cnt_en = 1'b1;
      if (cnt_tc) state_d = ST_IDLE;
    end

    // the holding slot frees up in the same cycle it is consumed
    if (word_done) begin
      if (!valid_q || dout_ready) begin
        dout_d  = shifted;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      dir_q     <= DIR_MSB_FIRST;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      dir_q     <= dir_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q == ST_SHIFT);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_word_rx.sv
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, dir, sin, sen, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  serial_word_rx #(.N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dir        (dir),
    .sin        (sin),
    .sen        (sen),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse, then seq[7] first .. seq[0] last, one strobe every gap cycles;
  // sin toggles on the idle cycles in between
  task automatic send_seq(input logic [7:0] seq, input logic d, input int gap,
                          output logic valid_before_last);
    start = 1'b1; dir = d; sen = 1'b0;
    tick();
    start = 1'b0;
    valid_before_last = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      for (int g = 1; g < gap; g++) begin
        sen = 1'b0; sin = ~sin;
        tick();
      end
      if (i == 0) valid_before_last = dout_valid;
      sen = 1'b1; sin = seq[i];
      tick();
    end
    sen = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%h valid=%b busy=%b overrun=%b, need 00/0/0/0",
               dout, dout_valid, busy, overrun);
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] seq = 8'b0001_1110;
    int busy_cnt = 0;
    int valid_cnt = 0;
    dout_ready = 1'b1;
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (busy === 1'b1) busy_cnt++;
      if (dout_valid === 1'b1) valid_cnt++;
      sen = 1'b1; sin = seq[i];
      tick();
    end
    sen = 1'b0;
    checks++;
    if (dout !== 8'h1E || dout_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL msb_word: dout=%h valid=%b busy=%b, need 1e/1/0", dout, dout_valid, busy);
    end
    checks++;
    if (busy_cnt != 8 || valid_cnt != 0) begin
      errors++;
      $display("FAIL msb_busy_len: busy cycles=%0d early valid=%0d, need 8/0", busy_cnt, valid_cnt);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h1E) begin
      errors++;
      $display("FAIL msb_valid_one_cycle: valid=%b dout=%h, need 0/1e", dout_valid, dout);
    end
  endtask

  task automatic test_lsb_first();
    logic vb;
    dout_ready = 1'b1;
    send_seq(8'b0001_1110, 1'b1, 1, vb);
    checks++;
    if (dout !== 8'h78 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL lsb_word: dout=%h valid=%b, need 78/1", dout, dout_valid);
    end
    tick();
  endtask

  task automatic test_sparse_strobe();
    logic vb;
    dout_ready = 1'b1;
    dir = 1'b1;
    send_seq(8'hA5, 1'b0, 3, vb);
    checks++;
    if (dout !== 8'hA5 || dout_valid !== 1'b1 || vb !== 1'b0) begin
      errors++;
      $display("FAIL sparse_word: dout=%h valid=%b valid_before=%b, need a5/1/0",
               dout, dout_valid, vb);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic vb;
    dout_ready = 1'b0;
    send_seq(8'h11, 1'b0, 1, vb);
    checks++;
    if (dout !== 8'h11 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: dout=%h valid=%b overrun=%b, need 11/1/0", dout, dout_valid, overrun);
    end
    send_seq(8'h22, 1'b0, 1, vb);
    checks++;
    if (dout !== 8'h11 || dout_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overrun: dout=%h valid=%b overrun=%b, need 11/1/1", dout, dout_valid, overrun);
    end
    tick();
    checks++;
    if (overrun !== 1'b0 || dout !== 8'h11) begin
      errors++;
      $display("FAIL b2b_overrun_pulse: overrun=%b dout=%h, need 0/11", overrun, dout);
    end
    dout_ready = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h11) begin
      errors++;
      $display("FAIL b2b_consume: valid=%b dout=%h, need 0/11", dout_valid, dout);
    end
  endtask

  task automatic test_restart();
    logic vb;
    int early_valid = 0;
    int ovr = 0;
    dout_ready = 1'b1;
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sen = 1'b1; sin = 1'b1;
      tick();
      if (dout_valid === 1'b1) early_valid++;
      if (overrun === 1'b1) ovr++;
    end
    sen = 1'b0;
    send_seq(8'hC3, 1'b0, 1, vb);
    checks++;
    if (dout !== 8'hC3 || dout_valid !== 1'b1 || overrun !== 1'b0 || vb !== 1'b0 ||
        early_valid != 0 || ovr != 0) begin
      errors++;
      $display("FAIL restart: dout=%h valid=%b overrun=%b early=%0d/%b ovr=%0d, need c3/1/0 0/0 0",
               dout, dout_valid, overrun, early_valid, vb, ovr);
    end
    tick();
  endtask

  task automatic test_start_with_sen();
    logic [7:0] seq = 8'h3C;
    dout_ready = 1'b1;
    // strobes while idle must not start anything
    sen = 1'b1; sin = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_sen: busy=%b valid=%b, need 0/0", busy, dout_valid);
    end
    // this strobe coincides with start and is discarded
    start = 1'b1; dir = 1'b0; sin = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sen = 1'b1; sin = seq[i];
      tick();
    end
    sen = 1'b0;
    checks++;
    if (dout !== 8'h3C || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL start_sen: dout=%h valid=%b, need 3c/1", dout, dout_valid);
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    logic vb;
    dout_ready = 1'b0;
    start = 1'b1; dir = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sen = 1'b1; sin = 1'b1;
      tick();
    end
    sen = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dout !== 8'h00 || dout_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: dout=%h valid=%b busy=%b overrun=%b, need 00/0/0/0",
               dout, dout_valid, busy, overrun);
    end
    tick();
    reset = 1'b0;
    dout_ready = 1'b1;
    send_seq(8'h5A, 1'b0, 1, vb);
    checks++;
    if (dout !== 8'h5A || dout_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: dout=%h valid=%b overrun=%b, need 5a/1/0", dout, dout_valid, overrun);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; dir = 1'b0; sin = 1'b0; sen = 1'b0; dout_ready = 1'b0;
    tick();
    test_reset();
    tick();
    reset = 1'b0;
    tick();
    test_msb_first();
    test_lsb_first();
    test_sparse_strobe();
    test_back_to_back();
    test_restart();
    test_start_with_sen();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
